// File: rtl/lane_step_sequencer.sv
// Game step sequencer for the 5-lane playfield: clears the field, then loops
// shift / load / draw / timed wait with a shrinking period until the game ends.
//
//  state  | meaning
//  IDLE   | waiting for start; last score and speed stay visible
//  CLEAR  | blanking pass before the first step
//  SHIFT  | advance lane registers one row
//  LOAD   | spawn a note on every LOAD_EVERY-th step
//  DRAW   | full playfield draw pass
//  WAIT   | step timer running, hit window open
//  OVER   | blanking pass after lives are exhausted
module lane_step_sequencer #(
    parameter int CW         = 26,
    parameter int STEP_INIT  = 40000000,
    parameter int STEP_MIN   = 10000000,
    parameter int STEP_DEC   = 1000,
    parameter int LOAD_EVERY = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          end_game_i,
    input  logic          pause_i,
    input  logic          draw_done_i,
    input  logic          clear_done_i,
    output logic          shift_o,
    output logic          load_o,
    output logic          lane_clear_o,
    output logic          draw_start_o,
    output logic          clear_start_o,
    output logic          hit_window_o,
    output logic          playing_o,
    output logic [2:0]    state_o,
    output logic [CW-1:0] step_period_o,
    output logic [15:0]   step_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_LOAD  = 3'd3,
        S_DRAW  = 3'd4,
        S_WAIT  = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    localparam logic [CW-1:0] P_INIT         = CW'(STEP_INIT);
    localparam logic [CW-1:0] P_MIN          = CW'(STEP_MIN);
    localparam logic [CW-1:0] P_DEC          = CW'(STEP_DEC);
    localparam logic [CW:0]   FLOOR_PLUS_DEC = (CW+1)'(STEP_MIN) + (CW+1)'(STEP_DEC);
    localparam logic [3:0]    SPAWN_LAST     = 4'(LOAD_EVERY - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] period_q, period_d;
    logic [15:0]   count_q, count_d;
    logic [3:0]    spawn_q, spawn_d;
    logic          shift_q, load_q, lclr_q, dstart_q, cstart_q;
    logic          shift_d, load_d, lclr_d, dstart_d, cstart_d;
    logic          game_over;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        period_d  = period_q;
        count_d   = count_q;
        spawn_d   = spawn_q;
        game_over = end_game_i &&
                    (state_q inside {S_SHIFT, S_LOAD, S_DRAW, S_WAIT});

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_CLEAR;
                    period_d = P_INIT;
                    count_d  = '0;
                    spawn_d  = '0;
                end
            end
            S_CLEAR: if (clear_done_i) state_d = S_SHIFT;
            S_SHIFT: begin
                spawn_d = (spawn_q >= SPAWN_LAST) ? 4'd0 : spawn_q + 4'd1;
                state_d = S_LOAD;
            end
            S_LOAD: state_d = S_DRAW;
            S_DRAW: begin
                if (draw_done_i) begin
                    state_d = S_WAIT;
                    wait_d  = period_q - CW'(1);
                end
            end
            S_WAIT: begin
                if (!pause_i) begin
                    if (wait_q == '0) begin
                        state_d = S_SHIFT;
                        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                        // floor check done before the subtract so the period never wraps
                        period_d = ({1'b0, period_q} >= FLOOR_PLUS_DEC) ? period_q - P_DEC : P_MIN;
                    end else begin
                        wait_d = wait_q - CW'(1);
                    end
                end
            end
            S_OVER: if (clear_done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (game_over) begin
            state_d  = S_OVER;
            wait_d   = wait_q;
            period_d = period_q;
            count_d  = count_q;
        end

        shift_d  = (state_d == S_SHIFT);
        load_d   = (state_d == S_LOAD) && (spawn_d == 4'd0);
        dstart_d = (state_d == S_DRAW) && (state_q != S_DRAW);
        cstart_d = ((state_d == S_CLEAR) && (state_q != S_CLEAR)) ||
                   ((state_d == S_OVER)  && (state_q != S_OVER));
        lclr_d   = cstart_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            period_q <= P_INIT;
            count_q  <= '0;
            spawn_q  <= '0;
            shift_q  <= 1'b0;
            load_q   <= 1'b0;
            lclr_q   <= 1'b0;
            dstart_q <= 1'b0;
            cstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            period_q <= period_d;
            count_q  <= count_d;
            spawn_q  <= spawn_d;
            shift_q  <= shift_d;
            load_q   <= load_d;
            lclr_q   <= lclr_d;
            dstart_q <= dstart_d;
            cstart_q <= cstart_d;
        end
    end

    assign shift_o       = shift_q;
    assign load_o        = load_q;
    assign lane_clear_o  = lclr_q;
    assign draw_start_o  = dstart_q;
    assign clear_start_o = cstart_q;
    assign hit_window_o  = (state_q == S_WAIT) && !pause_i;
    assign playing_o     = state_q inside {S_SHIFT, S_LOAD, S_DRAW, S_WAIT};
    assign state_o       = state_q;
    assign step_period_o = period_q;
    assign step_count_o  = count_q;

endmodule

// File: tb/tb_lane_step_sequencer.sv
// Randomized bench for lane_step_sequencer with a 3-cycle renderer model and a
// closed-form reference for step period, load cadence and wait length.
module tb_lane_step_sequencer;

    localparam int CW = 26;
    localparam int SI = 20;
    localparam int SM = 8;
    localparam int SD = 5;
    localparam int LE = 2;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0, end_game_i = 1'b0, pause_i = 1'b0;
    logic          inj_dd = 1'b0;
    logic          rdr_draw_done = 1'b0, rdr_clear_done = 1'b0;
    logic          draw_done_i, clear_done_i;
    logic          shift_o, load_o, lane_clear_o, draw_start_o, clear_start_o;
    logic          hit_window_o, playing_o;
    logic [2:0]    state_o;
    logic [CW-1:0] step_period_o;
    logic [15:0]   step_count_o;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            dcnt = 0, ccnt = 0;

    assign draw_done_i  = rdr_draw_done | inj_dd;
    assign clear_done_i = rdr_clear_done;

    lane_step_sequencer #(
        .CW(CW), .STEP_INIT(SI), .STEP_MIN(SM), .STEP_DEC(SD), .LOAD_EVERY(LE)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .end_game_i(end_game_i),
        .pause_i(pause_i), .draw_done_i(draw_done_i), .clear_done_i(clear_done_i),
        .shift_o(shift_o), .load_o(load_o), .lane_clear_o(lane_clear_o),
        .draw_start_o(draw_start_o), .clear_start_o(clear_start_o),
        .hit_window_o(hit_window_o), .playing_o(playing_o), .state_o(state_o),
        .step_period_o(step_period_o), .step_count_o(step_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // period of step k follows directly from the number of completed steps
    function automatic int exp_period(input int k);
        int p;
        p = SI - (k - 1) * SD;
        return (p < SM) ? SM : p;
    endfunction

    // renderer answers each start pulse with a done pulse 3 cycles later
    always begin
        @(posedge clk_i);
        #1;
        rdr_draw_done  = 1'b0;
        rdr_clear_done = 1'b0;
        if (dcnt > 0) begin dcnt--; if (dcnt == 0) rdr_draw_done = 1'b1; end
        if (ccnt > 0) begin ccnt--; if (ccnt == 0) rdr_clear_done = 1'b1; end
        if (draw_start_o === 1'b1) dcnt = 3;
        if (clear_start_o === 1'b1) ccnt = 3;
    end

    always @(negedge clk_i) begin
        chk("playing", 32'(playing_o), 32'(state_o >= 3'd2 && state_o <= 3'd5));
        chk("hit_window", 32'(hit_window_o), 32'(state_o == 3'd5 && !pause_i));
        chk("strobe_overlap", 32'(32'(shift_o) + 32'(load_o) + 32'(draw_start_o) + 32'(clear_start_o) <= 32'd1), 32'd1);
        chk("lane_clear_pair", 32'(lane_clear_o), 32'(clear_start_o));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // inputs are held for one cycle; outputs observed on the following negedge
    task automatic cyc(input logic st = 1'b0, input logic eg = 1'b0, input logic pz = 1'b0,
                       input logic dd = 1'b0, input logic rs = 1'b0);
        @(posedge clk_i);
        #1;
        start_i    = st;
        end_game_i = eg;
        pause_i    = pz;
        inj_dd     = dd;
        reset_i    = rs;
        @(negedge clk_i);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
        int n;
        n = 0;
        while (state_o !== tgt && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(state_o), 32'(tgt));
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_period"}, 32'(step_period_o), 32'(SI));
        chk({tag, "_count"}, 32'(step_count_o), 32'd0);
        chk({tag, "_hit"}, 32'(hit_window_o), 32'd0);
        chk({tag, "_strobes"}, 32'({shift_o, load_o, lane_clear_o, draw_start_o, clear_start_o}), 32'd0);
    endtask

    task automatic start_game();
        cyc(1'b1);
        cyc();
        chk("clear_state", 32'(state_o), 32'd1);
        chk("clear_lane_clear", 32'(lane_clear_o), 32'd1);
        chk("clear_start", 32'(clear_start_o), 32'd1);
        chk("start_count_reload", 32'(step_count_o), 32'd0);
        chk("start_period_reload", 32'(step_period_o), 32'(SI));
        cyc();
        chk("clear_pulse_once", 32'({lane_clear_o, clear_start_o}), 32'd0);
        wait_state(3'd2, 12, "clear_to_shift");
    endtask

    // mode: 0 normal, 1 end_game at wait expiry, 2 end_game in DRAW, 3 reset at counter 4
    task automatic do_step(input int k, input int plen, input int mode, input logic stray);
        int   p, poff, total;
        logic pz, eg, dd, rs;
        p     = exp_period(k);
        poff  = (plen > 0) ? int'($urandom_range(1, p - 2)) : 0;
        total = p + plen;
        chk("shift_state", 32'(state_o), 32'd2);
        chk("shift_strobe", 32'(shift_o), 32'd1);
        chk("count_at_shift", 32'(step_count_o), 32'(k - 1));
        cyc(1'b0, 1'b0, stray);
        chk("load_state", 32'(state_o), 32'd3);
        chk("load_strobe", 32'(load_o), 32'((k % LE) == 0));
        chk("shift_once", 32'(shift_o), 32'd0);
        cyc();
        chk("draw_state", 32'(state_o), 32'd4);
        chk("draw_start", 32'(draw_start_o), 32'd1);
        if (mode == 2) begin
            cyc(1'b0, 1'b1);
            cyc();
            chk("drawend_state", 32'(state_o), 32'd6);
            chk("drawend_clear", 32'({lane_clear_o, clear_start_o}), 32'd3);
            chk("drawend_count", 32'(step_count_o), 32'(k - 1));
            return;
        end
        cyc(stray);
        chk("draw_start_once", 32'(draw_start_o), 32'd0);
        chk("draw_ignores_start", 32'(state_o), 32'd4);
        wait_state(3'd5, 12, "draw_to_wait");
        chk("wait_period", 32'(step_period_o), 32'(p));
        for (int i = 1; i < total; i++) begin
            pz = (plen > 0) && (i >= poff) && (i < poff + plen);
            eg = (mode == 1) && (i == total - 1);
            dd = stray && (i == 2);
            rs = (mode == 3) && (i == p - 5);
            cyc(1'b0, eg, pz, dd, rs);
            chk("wait_hold", 32'(state_o), 32'd5);
            if (rs) begin
                cyc();
                chk_idle_reset("wait_reset");
                return;
            end
        end
        cyc();
        if (mode == 1) begin
            chk("over_state", 32'(state_o), 32'd6);
            chk("over_clear", 32'({lane_clear_o, clear_start_o}), 32'd3);
            chk("over_no_shift", 32'(shift_o), 32'd0);
            chk("over_count", 32'(step_count_o), 32'(k - 1));
            chk("over_period", 32'(step_period_o), 32'(p));
        end else begin
            chk("wait_expire", 32'(state_o), 32'd2);
            chk("step_count", 32'(step_count_o), 32'(k));
            chk("next_period", 32'(step_period_o), 32'(exp_period(k + 1)));
        end
    endtask

    task automatic finish_over(input int cnt, input int per);
        cyc(1'b1, 1'b1);
        cyc();
        chk("over_ignores_start", 32'(state_o), 32'd6);
        wait_state(3'd0, 12, "over_to_idle");
        chk("score_hold", 32'(step_count_o), 32'(cnt));
        chk("speed_hold", 32'(step_period_o), 32'(per));
        cyc(1'b0, 1'b1);
        cyc();
        chk("idle_ignores_end", 32'(state_o), 32'd0);
    endtask

    initial begin
        int n, plen;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk_idle_reset("reset");
        chk("reset_playing", 32'(playing_o), 32'd0);

        start_game();
        for (int k = 1; k <= 6; k++) begin
            plen = (k == 3) ? 7 : (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0);
            do_step(k, plen, (k == 6) ? 1 : 0, k == 2);
        end
        finish_over(5, exp_period(6));

        start_game();
        n = int'($urandom_range(2, 5));
        for (int k = 1; k <= n; k++) begin
            plen = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0;
            do_step(k, plen, 0, $urandom_range(0, 1) == 1);
        end
        do_step(n + 1, 0, 3, 1'b0);

        start_game();
        n = int'($urandom_range(1, 4));
        for (int k = 1; k <= n; k++) begin
            plen = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0;
            do_step(k, plen, 0, $urandom_range(0, 1) == 1);
        end
        do_step(n + 1, 0, 2, 1'b0);
        finish_over(n, exp_period(n + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
